// File: rtl/button_conditioner.sv
// Push-button front end: per-channel synchronizer, counter debouncer, press/release
// pulse generator and optional hold-to-repeat for the stopwatch controls.
module button_conditioner #(
  parameter int                 NUM_BTN         = 3,
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b100,
  parameter int                 REPEAT_DELAY    = 50000000,
  parameter int                 REPEAT_RATE     = 20000000,
  parameter int                 CNT_W           = 26
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rp_state_e;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      logic             sync1_q, sync2_q;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
      logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;
      rp_state_e        rp_state_q, rp_state_d;
      logic             rise, fall, rep_fire;

      // Debouncer: any agreement between sync2 and the level restarts the count.
      always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        if (sync2_q != level_q) begin
          if (db_cnt_q == DB_LAST) begin
            level_d = sync2_q;
            rise    = sync2_q;
            fall    = ~sync2_q;
          end else begin
            db_cnt_d = db_cnt_q + CNT_ONE;
          end
        end
      end

      always_comb begin
        rp_state_d = rp_state_q;
        rp_cnt_d   = rp_cnt_q;
        rep_fire   = 1'b0;
        case (rp_state_q)
          RP_IDLE: begin
            if (rise) begin
              rp_state_d = RP_DELAY;
              rp_cnt_d   = '0;
            end
          end
          RP_DELAY: begin
            if (fall) begin
              rp_state_d = RP_IDLE;
              rp_cnt_d   = '0;
            end else if (rp_cnt_q == RD_LAST) begin
              rep_fire   = 1'b1;
              rp_cnt_d   = '0;
              rp_state_d = RP_REPEAT;
            end else begin
              rp_cnt_d = rp_cnt_q + CNT_ONE;
            end
          end
          RP_REPEAT: begin
            // A release on the same edge as a due repeat wins; the repeat is dropped.
            if (fall) begin
              rp_state_d = RP_IDLE;
              rp_cnt_d   = '0;
            end else if (rp_cnt_q == RR_LAST) begin
              rep_fire = 1'b1;
              rp_cnt_d = '0;
            end else begin
              rp_cnt_d = rp_cnt_q + CNT_ONE;
            end
          end
          default: begin
            rp_state_d = RP_IDLE;
            rp_cnt_d   = '0;
          end
        endcase
        if (!REPEAT_MASK[gi]) begin
          rp_state_d = RP_IDLE;
          rp_cnt_d   = '0;
          rep_fire   = 1'b0;
        end
      end

      always_comb begin
        press_d   = rise | rep_fire;
        release_d = fall;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1_q    <= 1'b0;
          sync2_q    <= 1'b0;
          level_q    <= 1'b0;
          press_q    <= 1'b0;
          release_q  <= 1'b0;
          db_cnt_q   <= '0;
          rp_cnt_q   <= '0;
          rp_state_q <= RP_IDLE;
        end else begin
          sync1_q    <= btn_raw[gi];
          sync2_q    <= sync1_q;
          level_q    <= level_d;
          press_q    <= press_d;
          release_q  <= release_d;
          db_cnt_q   <= db_cnt_d;
          rp_cnt_q   <= rp_cnt_d;
          rp_state_q <= rp_state_d;
        end
      end

      assign btn_level[gi]   = level_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner; a rule-level reference model
// queues expected pulses and a negedge monitor compares them with the DUT outputs.
module tb_button_conditioner;

  localparam int         N    = 3;
  localparam int         D    = 4;
  localparam int         RD   = 10;
  localparam int         RR   = 3;
  localparam logic [2:0] MASK = 3'b100;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;

  button_conditioner #(
    .NUM_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_MASK(MASK),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int ch;
    bit rel;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  // Reference model: the synchronized input is the raw value two edges old; the level
  // follows it once it has disagreed for D consecutive edges. While held on a repeat
  // channel, extra presses land at RD, RD+RR, RD+2*RR, ... edges after the press.
  bit m_d1[N], m_d2[N], m_lvl[N];
  int m_run[N], m_since[N];
  bit m_seen, m_flip;
  int m_k;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_since[c] = 0;
      end
      exp_q.delete();
    end else begin
      cyc++;
      for (int c = 0; c < N; c++) begin
        m_seen = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = btn_raw[c];
        m_flip = 0;
        if (m_seen != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = m_seen;
            m_run[c] = 0;
            m_flip = 1;
            exp_q.push_back('{cyc: cyc, ch: c, rel: !m_seen});
            if (m_seen) m_since[c] = cyc;
          end
        end else begin
          m_run[c] = 0;
        end
        if (!m_flip && m_lvl[c] && MASK[c]) begin
          m_k = cyc - m_since[c];
          if (m_k >= RD && ((m_k - RD) % RR) == 0)
            exp_q.push_back('{cyc: cyc, ch: c, rel: 1'b0});
        end
      end
    end
  end

  // Monitor: collect this cycle's expected pulses and compare against the DUT.
  logic [N-1:0] ep, er, el;
  ev_t          ev;

  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if ({btn_level, btn_press, btn_release} != '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got lvl=%b prs=%b rel=%b want all 0",
                 cyc, btn_level, btn_press, btn_release);
      end
    end else begin
      ep = '0;
      er = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ev = exp_q.pop_front();
        if (ev.rel) er[ev.ch] = 1'b1;
        else        ep[ev.ch] = 1'b1;
      end
      for (int c = 0; c < N; c++) el[c] = m_lvl[c];
      checks++;
      if (btn_press !== ep) begin
        errors++;
        $display("FAIL press cyc=%0d got %b want %b", cyc, btn_press, ep);
      end
      checks++;
      if (btn_release !== er) begin
        errors++;
        $display("FAIL release cyc=%0d got %b want %b", cyc, btn_release, er);
      end
      checks++;
      if (btn_level !== el) begin
        errors++;
        $display("FAIL level cyc=%0d got %b want %b", cyc, btn_level, el);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Wait (bounded) for a pulse on channel ch and check its distance from start.
  task automatic wait_pulse(input int ch, input bit rel, input int start,
                            input int want, input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (rel ? btn_release[ch] : btn_press[ch]) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s no pulse within 40 cycles, want one %0d edges after start", name, want);
    end else if (cyc - start != want) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, cyc - start, want);
    end else begin
      $display("ok %s at cyc=%0d latency %0d", name, cyc, want);
    end
  endtask

  int k0;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);

    // Clean press then release on channel 0
    k0 = cyc; btn_raw[0] = 1'b1;
    wait_pulse(0, 1'b0, k0, 6, "s1_press");
    tick(5);
    k0 = cyc; btn_raw[0] = 1'b0;
    wait_pulse(0, 1'b1, k0, 6, "s3_release");
    tick(3);

    // Bounce on channel 1
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(2);
    k0 = cyc; btn_raw[1] = 1'b1;
    wait_pulse(1, 1'b0, k0, 6, "s2_press");
    tick(3);
    btn_raw[1] = 1'b0;
    tick(10);

    // Auto-repeat on channel 2
    k0 = cyc; btn_raw[2] = 1'b1;
    wait_pulse(2, 1'b0, k0, 6, "s4_press");
    k0 = cyc;
    wait_pulse(2, 1'b0, k0, 10, "s4_repeat1");
    k0 = cyc;
    wait_pulse(2, 1'b0, k0, 3, "s4_repeat2");
    tick(7);
    btn_raw[2] = 1'b0;
    tick(12);

    // Reset in the middle of a debounce
    btn_raw[0] = 1'b1;
    tick(5);
    #2 reset = 1'b1;
    tick(3);
    k0 = cyc; reset = 1'b0;
    wait_pulse(0, 1'b0, k0, 6, "s5_press");
    btn_raw[0] = 1'b0;
    tick(10);

    // Simultaneous presses on independent channels
    k0 = cyc; btn_raw = 3'b101;
    wait_pulse(0, 1'b0, k0, 6, "s6_press");
    checks++;
    if (btn_press !== 3'b101) begin
      errors++;
      $display("FAIL s6_coincident got %b want 101", btn_press);
    end
    tick(4);
    btn_raw = '0;
    tick(12);

    // Random toggling with occasional long holds and resets
    for (int it = 0; it < 250; it++) begin
      btn_raw = btn_raw ^ 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 30));
      else                           tick($urandom_range(1, 5));
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    btn_raw = '0;
    tick(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
